// File: rtl/sfp_arb_pkg.sv
// sfp_arb_pkg: shared types and helpers for the SFP read arbiters
package sfp_arb_pkg;

    typedef enum logic [1:0] {IDLE, XFER, GAP} arb_state_t;

    localparam int GAP_CYCLES = 1;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request above the last-served index (with wrap)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] win,
    output logic          found
);

    // scan from farthest to nearest so the nearest request after last wins
    always_comb begin
        win = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last) + k) % N]) win = IW'((int'(last) + k) % N);
        end
    end

    assign found = |req;

endmodule

// File: rtl/sfp_read_arbiter.sv
// sfp_read_arbiter: round-robin burst scheduler draining NUM_CH FWFT FIFOs into one stream
module sfp_read_arbiter
    import sfp_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 256,
    parameter int ID_W      = 2
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic [NUM_CH-1:0]        CH_REQUEST,
    input  logic [NUM_CH-1:0]        CH_EMPTY,
    input  logic [NUM_CH*DATA_W-1:0] CH_DOUT,
    output logic [NUM_CH-1:0]        CH_RD_EN,
    output logic [DATA_W-1:0]        M_TDATA,
    output logic                     M_TVALID,
    input  logic                     M_TREADY,
    output logic                     M_TLAST,
    output logic [ID_W-1:0]          GRANT_ID,
    output logic                     BUSY
);

    localparam int CW = clog2(MAX_BURST);

    arb_state_t      state, state_nx;
    logic [ID_W-1:0] grant, last_served, pick;
    logic [CW-1:0]   cnt;
    logic [NUM_CH-1:0] q;
    logic            any_q, g_empty, valid, hs, last_beat, gap_done;

    assign q = CH_REQUEST & ~CH_EMPTY;

    rr_pick #(.N(NUM_CH), .IW(ID_W)) u_pick (
        .req   (q),
        .last  (last_served),
        .win   (pick),
        .found (any_q)
    );

    assign g_empty   = CH_EMPTY[grant];
    assign last_beat = cnt == CW'(MAX_BURST - 1);
    assign gap_done  = cnt == CW'(GAP_CYCLES - 1);

    // outputs are gated by RESETN so a reset mid-burst stops pops in the same cycle
    assign valid    = RESETN && state == XFER && !g_empty;
    assign hs       = valid & M_TREADY;
    assign M_TVALID = valid;
    assign M_TDATA  = valid ? CH_DOUT[int'(grant)*DATA_W +: DATA_W] : '0;
    assign M_TLAST  = valid & last_beat;
    assign CH_RD_EN = hs ? NUM_CH'(1) << grant : '0;
    assign GRANT_ID = RESETN ? grant : '0;
    assign BUSY     = RESETN && state != IDLE;

    // next state: arbitrate, drain until empty or burst limit, then one gap cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_q ? XFER : IDLE;
            XFER:    state_nx = (g_empty || (hs && last_beat)) ? GAP : XFER;
            GAP:     state_nx = gap_done ? IDLE : GAP;
            default: state_nx = IDLE;
        endcase
    end

    // state, grant, rotation pointer and beat/gap counter
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state       <= IDLE;
            grant       <= '0;
            last_served <= ID_W'(NUM_CH - 1);
            cnt         <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_q) begin
                grant <= pick;
                cnt   <= '0;
            end else if (state == XFER) begin
                cnt <= (state_nx == GAP) ? '0 : cnt + CW'(hs);
            end else if (state == GAP) begin
                last_served <= grant;
                cnt         <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sfp_read_arbiter.sv
// tb_sfp_read_arbiter: scoreboard bench with FWFT FIFO models feeding the arbiter
module tb_sfp_read_arbiter;

    localparam int NC = 4;
    localparam int DW = 64;
    localparam int MB = 16;
    localparam int IW = 2;
    localparam int DEPTH = 64;

    typedef struct {
        int          ch;
        logic [63:0] data;
        logic        last;
        int          gap;
    } exp_t;

    logic              CLK = 0;
    logic              RESETN;
    logic [NC-1:0]     CH_REQUEST;
    logic [NC-1:0]     CH_EMPTY;
    logic [NC*DW-1:0]  CH_DOUT;
    logic [NC-1:0]     CH_RD_EN;
    logic [DW-1:0]     M_TDATA;
    logic              M_TVALID;
    logic              M_TREADY;
    logic              M_TLAST;
    logic [IW-1:0]     GRANT_ID;
    logic              BUSY;

    logic [63:0] mem [NC][DEPTH];
    int head [NC] = '{default: 0};
    int tail [NC] = '{default: 0};
    int pops [NC] = '{default: 0};
    int beats [NC] = '{default: 0};
    int cyc = 0;
    int last_hs = 0;
    int n_chk = 0;
    int n_fail = 0;
    exp_t sb[$];
    exp_t e;

    sfp_read_arbiter #(.NUM_CH(NC), .DATA_W(DW), .MAX_BURST(MB), .ID_W(IW)) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .CH_REQUEST (CH_REQUEST),
        .CH_EMPTY   (CH_EMPTY),
        .CH_DOUT    (CH_DOUT),
        .CH_RD_EN   (CH_RD_EN),
        .M_TDATA    (M_TDATA),
        .M_TVALID   (M_TVALID),
        .M_TREADY   (M_TREADY),
        .M_TLAST    (M_TLAST),
        .GRANT_ID   (GRANT_ID),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < NC; g++) begin : g_fifo
        assign CH_EMPTY[g] = head[g] == tail[g];
        assign CH_DOUT[g*DW +: DW] = mem[g][head[g] % DEPTH];
    end

    // FWFT FIFO models pop on the arbiter's read enable
    always @(posedge CLK) begin
        for (int i = 0; i < NC; i++) begin
            if (CH_RD_EN[i]) begin
                head[i] <= head[i] + 1;
                pops[i] <= pops[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dw(input int ch, input int idx);
        return {32'(ch) + 32'h5F00, 32'(idx)};
    endfunction

    task automatic fill(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            mem[ch][tail[ch] % DEPTH] = dw(ch, tail[ch]);
            tail[ch]++;
        end
    endtask

    task automatic expect_burst(input int ch, input int start, input int n, input int gap);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.ch   = ch;
            x.data = dw(ch, start + k);
            x.last = (n == MB) && (k == n - 1);
            x.gap  = (k == 0) ? gap : -1;
            sb.push_back(x);
        end
    endtask

    task automatic wait_idle();
        int t;
        for (t = 0; t < 1000; t++) begin
            @(posedge CLK);
            #1;
            if (sb.size() == 0 && !BUSY) break;
        end
        if (t == 1000) check("idle_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic wait_beats(input int ch, input int n);
        int t = 0;
        while (beats[ch] < n && t < 300) begin
            @(posedge CLK);
            t++;
        end
        if (beats[ch] < n) check("beat_timeout", 64'(beats[ch]), 64'(n));
    endtask

    // scoreboard: every completed handshake must match the next predicted beat
    always @(negedge CLK) begin
        cyc++;
        if (M_TVALID && M_TREADY) begin
            if (sb.size() == 0) begin
                check("extra_beat", M_TDATA, 64'd0);
            end else begin
                e = sb.pop_front();
                check("tdata", M_TDATA, e.data);
                check("grant_id", 64'(GRANT_ID), 64'(e.ch));
                check("tlast", 64'(M_TLAST), 64'(e.last));
                check("rd_en", 64'(CH_RD_EN), 64'(1) << e.ch);
                if (e.gap >= 0) check("burst_gap", 64'(cyc - last_hs - 1), 64'(e.gap));
            end
            last_hs = cyc;
            beats[GRANT_ID]++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        RESETN = 0;
        CH_REQUEST = '0;
        M_TREADY = 1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_valid", 64'(M_TVALID), 64'd0);
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_grant", 64'(GRANT_ID), 64'd0);
        check("rst_rd_en", 64'(CH_RD_EN), 64'd0);
        check("rst_tlast", 64'(M_TLAST), 64'd0);
        @(posedge CLK);
        #1 RESETN = 1;
        wait_idle();

        // single channel, burst shorter than MAX_BURST, ends when FIFO empties
        fill(0, 10);
        expect_burst(0, 0, 10, -1);
        CH_REQUEST = 4'b0001;
        @(negedge CLK);
        check("arb_cycle_valid", 64'(M_TVALID), 64'd0);
        @(negedge CLK);
        check("first_valid", 64'(M_TVALID), 64'd1);
        check("first_grant", 64'(GRANT_ID), 64'd0);
        wait_idle();
        check("ch0_pops", 64'(pops[0]), 64'd10);
        CH_REQUEST = '0;

        // two channels alternate full bursts; last served was 0 so 2 goes first
        fill(0, 32);
        fill(2, 32);
        expect_burst(2, 0, 16, -1);
        expect_burst(0, 10, 16, 2);
        expect_burst(2, 16, 16, 2);
        expect_burst(0, 26, 16, 2);
        CH_REQUEST = 4'b0101;
        wait_idle();
        CH_REQUEST = '0;

        // backpressure: ready 1,0,0,1 holds the beat
        fill(1, 3);
        expect_burst(1, 0, 3, -1);
        CH_REQUEST = 4'b0010;
        @(posedge CLK);
        @(posedge CLK);
        #1 M_TREADY = 0;
        for (int s = 0; s < 2; s++) begin
            @(negedge CLK);
            check("stall_valid", 64'(M_TVALID), 64'd1);
            check("stall_data", M_TDATA, dw(1, 1));
            check("stall_rd_en", 64'(CH_RD_EN), 64'd0);
        end
        @(posedge CLK);
        #1 M_TREADY = 1;
        wait_idle();
        CH_REQUEST = '0;

        // wrap-around: serve 3, then 0 outranks 3
        fill(3, 2);
        expect_burst(3, 0, 2, -1);
        CH_REQUEST = 4'b1000;
        wait_idle();
        fill(0, 2);
        fill(3, 2);
        expect_burst(0, 42, 2, -1);
        expect_burst(3, 2, 2, 3);
        CH_REQUEST = 4'b1001;
        wait_idle();
        CH_REQUEST = '0;

        // request drops after beat 2; all six words still drain
        fill(1, 6);
        expect_burst(1, 3, 6, -1);
        CH_REQUEST = 4'b0010;
        wait_beats(1, 5);
        #1 CH_REQUEST = '0;
        wait_idle();
        check("ch1_pops", 64'(pops[1]), 64'd9);

        // reset mid-burst after three beats of channel 2
        fill(2, 8);
        expect_burst(2, 32, 3, -1);
        CH_REQUEST = 4'b0100;
        wait_beats(2, 35);
        #1 RESETN = 0;
        fill(0, 2);
        CH_REQUEST = 4'b0101;
        @(negedge CLK);
        check("midrst_rd_en", 64'(CH_RD_EN), 64'd0);
        check("midrst_valid", 64'(M_TVALID), 64'd0);
        check("midrst_busy", 64'(BUSY), 64'd0);
        check("midrst_grant", 64'(GRANT_ID), 64'd0);
        @(posedge CLK);
        #1 RESETN = 1;
        expect_burst(0, 44, 2, -1);
        expect_burst(2, 35, 5, -1);
        @(negedge CLK);
        check("post_rst_busy", 64'(BUSY), 64'd0);
        check("post_rst_valid", 64'(M_TVALID), 64'd0);
        wait_idle();
        CH_REQUEST = '0;

        check("ch0_total_pops", 64'(pops[0]), 64'd46);
        check("ch2_total_pops", 64'(pops[2]), 64'd40);
        check("ch3_total_pops", 64'(pops[3]), 64'd4);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sfp_read_arbiter.md
Name: sfp_read_arbiter

Overview:
- Round-robin scheduler sharing one SFP transmit stream among NUM_CH first-word-fall-through (FWFT) FIFOs.
- Each FIFO has its own hysteresis read-request generator. This block picks one requesting channel and drains it in a bounded burst.
- It then rotates the grant to the next channel.
- Sits between the per-channel FIFO/read-request pairs and the SFP framer's AXI-Stream-style input.

Parameters:
- NUM_CH, 4, number of channels (2..8).
- DATA_W, 64, FIFO/stream data width.
- MAX_BURST, 256, maximum beats per grant (2..65535).
- ID_W, 2, width of GRANT_ID; must satisfy 2**ID_W >= NUM_CH.

Ports:
- CLK  in  1  clock.
- RESETN  in  1  synchronous active-low reset.
- CH_REQUEST  in  NUM_CH  per-channel read request (hysteresis-filtered prog-full/prog-empty).
- CH_EMPTY  in  NUM_CH  per-channel FIFO empty flag (FWFT: dout valid when 0).
- CH_DOUT  in  NUM_CH*DATA_W  concatenated FIFO outputs; channel i is bits [i*DATA_W +: DATA_W].
- CH_RD_EN  out  NUM_CH  per-channel FIFO pop; one-hot or zero.
- M_TDATA  out  DATA_W  granted channel data.
- M_TVALID  out  1  data valid.
- M_TREADY  in  1  downstream ready.
- M_TLAST  out  1  last beat of a MAX_BURST-length burst.
- GRANT_ID  out  ID_W  index of the granted channel; stable for the whole burst.
- BUSY  out  1  high in XFER and GAP.

Behaviour:
- Reset is decided: RESETN synchronous, active-low; clock CLK. Reset forces:
  - state IDLE, grant register 0, last-served pointer NUM_CH-1, beat counter 0;
  - all outputs 0: CH_RD_EN=0, M_TVALID=0, M_TLAST=0, GRANT_ID=0, BUSY=0.
- Qualified request: q[i] = CH_REQUEST[i] & ~CH_EMPTY[i].
- States: IDLE, XFER, GAP. Binary encoded, registered.
- IDLE:
  - If any q[i] is set, pick the first set bit searching upward (with wrap) from last_served+1.
  - Register that index as GRANT_ID, clear the beat counter, go to XFER at the next edge.
  - Latency from q rising to first M_TVALID is 1 cycle.
  - If no q bit is set, stay in IDLE.
- XFER (g = GRANT_ID):
  - M_TVALID = ~CH_EMPTY[g] (combinational).
  - M_TDATA = CH_DOUT[g].
  - CH_RD_EN[g] = M_TVALID & M_TREADY; all other channels 0.
  - M_TLAST = M_TVALID & (count == MAX_BURST-1).
  - On each handshake, count increments.
  - Burst ends, and the next state is GAP, when either:
    - a handshake occurs with count == MAX_BURST-1; or
    - CH_EMPTY[g] == 1 in XFER (FIFO ran dry). No beat is issued that cycle and M_TLAST is not asserted.
  - CH_REQUEST[g] deasserting mid-burst does not end the burst; the channel drains until empty or MAX_BURST.
  - M_TVALID must never drop while M_TREADY=0 unless the FIFO itself is empty. The FIFO cannot empty without a pop, so TVALID is held.
- GAP:
  - One idle cycle: M_TVALID=0, no pops.
  - last_served <= g; go to IDLE.
  - Minimum spacing between bursts is 2 cycles (GAP + IDLE arbitration).
- Fairness:
  - A channel granted last is lowest priority next round.
  - A single requesting channel is re-granted after GAP+IDLE.
- Counter width is clog2(MAX_BURST). Overflow is impossible because the count clears on every grant.
- Reset mid-burst: abort immediately. The in-flight beat is lost, and pops stop in the reset cycle (CH_RD_EN=0 while RESETN=0).

Decomposition:
- Package sfp_arb_pkg: state enum (IDLE/XFER/GAP), clog2 function, GAP_CYCLES constant = 1.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: request vector, last pointer.
  - Outputs: winner index, any-valid flag.
  - Reusable by other SFP_IF arbiters.

Test Plan:
- Reset, then CH_REQUEST=0001 with FIFO0 holding 10 words, TREADY=1 → GRANT_ID=0 one cycle after q rises; 10 beats with M_TLAST=0; empty → GAP → IDLE; CH_RD_EN[0] pulsed exactly 10 times.
- MAX_BURST=4; channels 0 and 2 each hold 8 words, both requesting → bursts 0,2,0,2 of 4 beats each; M_TLAST on every 4th beat; 2 idle cycles between bursts.
- Backpressure: toggle TREADY 1,0,0,1 during a burst → M_TVALID and M_TDATA held while stalled; no CH_RD_EN while TREADY=0; beat count unchanged.
- Wrap-around: last_served=3 with requests 1001 → channel 0 granted next, then channel 3.
- Request drops mid-burst (CH_REQUEST[1] falls after beat 2, FIFO1 holds 6 words) → all 6 beats still sent.
- RESETN low for 1 cycle mid-burst → next cycle all outputs 0 and state IDLE; after release, arbitration resumes from channel 0.
